// File: rtl/sig_activity_monitor.sv
// Runtime toggle/idle monitor: counts per-channel toggles of NUM_CH signals over a
// programmable window and reports idle channels and the level they were stuck at.
module sig_activity_monitor #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned WINDOW_W = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic [NUM_CH-1:0]   sig_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_CH-1:0]   idle_mask,
  output logic [NUM_CH-1:0]   stuck_val,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [CNT_W-1:0]    rd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  load_c;
  logic                  arm_c;
  logic                  cmp_c;
  logic                  fin_c;

  logic [WINDOW_W-1:0]   win_len_q;
  logic [WINDOW_W-1:0]   remaining_q;
  logic [NUM_CH-1:0]     prev_q;
  logic [NUM_CH-1:0]     toggle_c;
  logic [NUM_CH-1:0]     idle_c;
  logic [CNT_W-1:0]      cnt_q [NUM_CH];

  // Next-state and datapath strobes; abort wins over the COUNT->DONE exit.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    arm_c   = 1'b0;
    cmp_c   = 1'b0;
    fin_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          load_c  = 1'b1;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_COUNT;
          arm_c   = 1'b1;
        end
      end
      S_COUNT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cmp_c = 1'b1;
          if (remaining_q == WINDOW_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        fin_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_ARM) || (state_d == S_COUNT);
      done    <= (state_d == S_DONE);
    end
  end

  assign toggle_c = sig_in ^ prev_q;

  always_comb begin
    idle_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idle_c[i] = (cnt_q[i] == '0);
    end
  end

  // Window bookkeeping; a zero length is promoted to one so remaining never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len_q   <= '0;
      remaining_q <= '0;
      prev_q      <= '0;
    end else begin
      if (load_c) begin
        win_len_q <= (window_len == '0) ? WINDOW_W'(1) : window_len;
      end
      if (arm_c) begin
        prev_q      <= sig_in;
        remaining_q <= win_len_q;
      end else if (cmp_c) begin
        prev_q      <= sig_in;
        remaining_q <= remaining_q - WINDOW_W'(1);
      end
    end
  end

  // Saturating per-channel toggle counters, cleared only on ARM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (arm_c) begin
          cnt_q[i] <= '0;
        end else if (cmp_c && toggle_c[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Results are captured on the DONE edge and held until the next DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_mask <= '0;
      stuck_val <= '0;
    end else if (fin_c) begin
      idle_mask <= idle_c;
      stuck_val <= prev_q;
    end
  end

  // Combinational count readout; selects beyond NUM_CH read as zero.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_cnt = cnt_q[i];
      end
    end
  end

endmodule

// File: tb/tb_sig_activity_monitor.sv
// Self-checking bench for sig_activity_monitor: a reference model fills a scoreboard
// per accepted start, and results are popped and compared when done is seen.
module tb_sig_activity_monitor;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned WINDOW_W = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SEL_W    = 4;

  typedef struct packed {
    logic [NUM_CH-1:0]           idle;
    logic [NUM_CH-1:0]           stuck;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [WINDOW_W-1:0] window_len;
  logic [NUM_CH-1:0]   sig_in;
  logic                busy;
  logic                done;
  logic [NUM_CH-1:0]   idle_mask;
  logic [NUM_CH-1:0]   stuck_val;
  logic [SEL_W-1:0]    rd_sel;
  logic [CNT_W-1:0]    rd_cnt;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [NUM_CH-1:0] seq [0:511];

  sig_activity_monitor #(
    .NUM_CH(NUM_CH), .WINDOW_W(WINDOW_W), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .window_len(window_len), .sig_in(sig_in), .busy(busy), .done(done),
    .idle_mask(idle_mask), .stuck_val(stuck_val), .rd_sel(rd_sel), .rd_cnt(rd_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic exp_t model(input int n);
    exp_t e;
    e = '0;
    for (int k = 1; k <= n; k++) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if ((seq[k][i] != seq[k-1][i]) && (e.cnt[i] != 8'hFF)) e.cnt[i] = e.cnt[i] + 8'd1;
      end
    end
    for (int i = 0; i < int'(NUM_CH); i++) e.idle[i] = (e.cnt[i] == 8'd0);
    e.stuck = seq[n];
    return e;
  endfunction

  // Caller is #1 after an edge with the DUT in IDLE; returns #1 after the post-DONE edge.
  task automatic run_window(input int n, input int len_field, input bit poke_start);
    exp_t e;
    int cyc;
    bit seen;
    sb.push_back(model(n));
    start = 1'b1; window_len = WINDOW_W'(len_field); sig_in = seq[0];
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy: got %b want 1", busy); end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      sig_in = seq[k];
      start  = poke_start && (k == 2);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL count_flags k=%0d: busy=%b done=%b want 1/0", k, busy, done);
      end
    end
    cyc = n; seen = 1'b0;
    for (int w = 0; w < 8 && !seen; w++) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL done_timeout: no done within %0d cycles", cyc + 1);
      return;
    end
    if (cyc != n + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_latency: latency=%0d busy=%b want %0d/0", cyc + 1, busy, n + 2);
    end
    start = poke_start;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_done_flags: done=%b busy=%b want 0/0", done, busy);
    end
    checks++;
    if (idle_mask !== e.idle) begin
      errors++; $display("FAIL idle_mask: got %h want %h", idle_mask, e.idle);
    end
    checks++;
    if (stuck_val !== e.stuck) begin
      errors++; $display("FAIL stuck_val: got %h want %h", stuck_val, e.stuck);
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      rd_sel = SEL_W'(i); #1;
      checks++;
      if (rd_cnt !== e.cnt[i]) begin
        errors++; $display("FAIL rd_cnt ch%0d: got %0d want %0d", i, rd_cnt, e.cnt[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; window_len = '0; sig_in = '0; rd_sel = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || idle_mask !== '0 || stuck_val !== '0 || rd_cnt !== '0) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b idle=%h stuck=%h cnt=%0d want all 0",
                         busy, done, idle_mask, stuck_val, rd_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    for (int k = 0; k <= 4; k++) seq[k] = {6'b0, 1'b1, k[0]};
    run_window(4, 4, 1'b0);
    checks++;
    if (idle_mask !== 8'hFE || stuck_val !== 8'h02) begin
      errors++; $display("FAIL basic_const: idle=%h stuck=%h want fe/02", idle_mask, stuck_val);
    end
  endtask

  task automatic test_saturation;
    for (int k = 0; k <= 300; k++) seq[k] = 8'h40 | (k[0] ? 8'h08 : 8'h00);
    run_window(300, 300, 1'b0);
    rd_sel = 4'd3; #1;
    checks++;
    if (rd_cnt !== 8'd255 || idle_mask[3] !== 1'b0) begin
      errors++; $display("FAIL saturation: cnt=%0d idle3=%b want 255/0", rd_cnt, idle_mask[3]);
    end
  endtask

  task automatic test_zero_len;
    seq[0] = 8'h00; seq[1] = 8'h81;
    run_window(1, 0, 1'b0);
  endtask

  task automatic test_random_back_to_back;
    logic [NUM_CH-1:0] act, base;
    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(2, 12));
      act = NUM_CH'($urandom); base = NUM_CH'($urandom);
      for (int k = 0; k <= n; k++) seq[k] = (base & ~act) | (NUM_CH'($urandom) & act);
      run_window(n, n, r[0]);
    end
  endtask

  task automatic test_readout_hold;
    for (int k = 0; k <= 6; k++) seq[k] = (k[0] ? 8'h04 : 8'h00) | (k == 3 ? 8'h20 : 8'h00);
    run_window(6, 6, 1'b0);
    repeat (3) @(posedge clk);
    #1 rd_sel = 4'd2; #1;
    checks++;
    if (rd_cnt !== 8'd6) begin errors++; $display("FAIL rd_hold ch2: got %0d want 6", rd_cnt); end
    rd_sel = 4'd5; #1;
    checks++;
    if (rd_cnt !== 8'd2) begin errors++; $display("FAIL rd_hold ch5: got %0d want 2", rd_cnt); end
    rd_sel = 4'd9; #1;
    checks++;
    if (rd_cnt !== 8'd0) begin errors++; $display("FAIL rd_sel9: got %0d want 0", rd_cnt); end
    rd_sel = 4'd15; #1;
    checks++;
    if (rd_cnt !== 8'd0) begin errors++; $display("FAIL rd_sel15: got %0d want 0", rd_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    for (int k = 0; k <= 5; k++) seq[k] = 8'hA0 | (k[0] ? 8'h0F : 8'h00);
    run_window(5, 5, 1'b0);
    start = 1'b1; window_len = 16'd10; sig_in = 8'h33;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sig_in = 8'hCC;
    @(posedge clk); #1;
    start = 1'b0; sig_in = 8'h33;
    @(posedge clk); #1;
    abort = 1'b1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_exit: busy=%b done=%b want 0/0", busy, done);
    end
    for (int w = 0; w < 4; w++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || idle_mask !== 8'hF0 || stuck_val !== 8'hAF) begin
        errors++; $display("FAIL abort_hold w=%0d: busy=%b done=%b idle=%h stuck=%h want 0/0/f0/af",
                           w, busy, done, idle_mask, stuck_val);
      end
    end
  endtask

  task automatic test_reset_mid_count;
    start = 1'b1; window_len = 16'd20; sig_in = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1 sig_in = ~sig_in; end
    rst_n = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || idle_mask !== '0 || stuck_val !== '0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b idle=%h stuck=%h want 0/0/00/00",
                         busy, done, idle_mask, stuck_val);
    end
    for (int i = 0; i < 16; i++) begin
      rd_sel = SEL_W'(i); #0.5;
      checks++;
      if (rd_cnt !== '0) begin errors++; $display("FAIL reset_mid_cnt sel%0d: got %0d want 0", i, rd_cnt); end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: busy=%b done=%b want 0/0", busy, done);
    end
    for (int k = 0; k <= 2; k++) seq[k] = 8'h10 << k;
    run_window(2, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_saturation();
    test_random_back_to_back();
    test_readout_hold();
    test_abort();
    test_reset_mid_count();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
